// File: rtl/bip_pkg.sv
// Shared types and constants for the accumulator CPU control unit.
// Opcodes, FSM state encoding, datapath mux codes and the decoded control bundle.
package bip_pkg;

  localparam int PC_WIDTH      = 11;
  localparam int OPERAND_WIDTH = 11;
  localparam int OPCODE_WIDTH  = 5;
  localparam int INSTR_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam int COUNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_need;
    logic       is_halt;
  } ctrl_t;

endpackage

// File: rtl/bip_if.sv
// Control interface between the control unit (master) and program memory / datapath (slave).
interface bip_if;
  import bip_pkg::*;

  logic                     enable;
  logic [INSTR_WIDTH-1:0]   instr_in;
  logic [PC_WIDTH-1:0]      pc_out;
  logic [OPERAND_WIDTH-1:0] data_addr;
  logic                     rd_ram;
  logic                     wr_ram;
  logic [OPERAND_WIDTH-1:0] imm_operand;
  logic [1:0]               SelA;
  logic                     SelB;
  logic                     WrAcc;
  logic                     Op;
  logic                     halted;
  logic [COUNT_WIDTH-1:0]   instr_count;

  modport master (
    input  enable, instr_in,
    output pc_out, data_addr, rd_ram, wr_ram, imm_operand,
           SelA, SelB, WrAcc, Op, halted, instr_count
  );

  modport slave (
    output enable, instr_in,
    input  pc_out, data_addr, rd_ram, wr_ram, imm_operand,
           SelA, SelB, WrAcc, Op, halted, instr_count
  );

endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps an opcode to the datapath control bundle.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OPC_HLT:  ctrl.is_halt = 1'b1;
      OPC_STO:  ctrl.wr_ram  = 1'b1;
      OPC_LD: begin
        ctrl.sel_a   = SEL_A_MEM;
        ctrl.wr_acc  = 1'b1;
        ctrl.rd_need = 1'b1;
      end
      OPC_LDI: begin
        ctrl.sel_a  = SEL_A_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI: begin
        ctrl.sel_a   = SEL_A_ALU;
        ctrl.sel_b   = (opcode == OPC_ADDI || opcode == OPC_SUBI) ? SEL_B_IMM : SEL_B_MEM;
        ctrl.op      = (opcode == OPC_SUB  || opcode == OPC_SUBI) ? OP_SUB : OP_ADD;
        ctrl.wr_acc  = 1'b1;
        ctrl.rd_need = (opcode == OPC_ADD  || opcode == OPC_SUB);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// Multi-cycle control unit: FSM, PC, IR and retired-instruction counter around the decoder.
//   state   | meaning
//   FETCH   | pc_out presented to program memory
//   DECODE  | instr_in valid, captured into IR; operand read issued for LD/ADD/SUB
//   EXECUTE | datapath controls driven from IR; PC and count advance
//   HALT    | terminal, left only by reset
module bip_control
  import bip_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  bip_if.master bus
);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  ctrl_t                  dec_ctrl;
  ctrl_t                  exe_ctrl;

  // One decoder looks ahead at instr_in for the DECODE read, the other drives EXECUTE from IR.
  bip_decoder u_dec_in (
    .opcode (bus.instr_in[INSTR_WIDTH-1:OPERAND_WIDTH]),
    .ctrl   (dec_ctrl)
  );

  bip_decoder u_dec_ir (
    .opcode (ir_q[INSTR_WIDTH-1:OPERAND_WIDTH]),
    .ctrl   (exe_ctrl)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    count_d         = count_q;
    bus.data_addr   = ir_q[OPERAND_WIDTH-1:0];
    bus.imm_operand = '0;
    bus.rd_ram      = 1'b0;
    bus.wr_ram      = 1'b0;
    bus.SelA        = SEL_A_MEM;
    bus.SelB        = SEL_B_MEM;
    bus.Op          = OP_ADD;
    bus.WrAcc       = 1'b0;
    bus.halted      = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.enable) state_d = DECODE;
      end
      DECODE: begin
        bus.data_addr = bus.instr_in[OPERAND_WIDTH-1:0];
        bus.rd_ram    = bus.enable & dec_ctrl.rd_need;
        if (bus.enable) begin
          ir_d    = bus.instr_in;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        bus.imm_operand = ir_q[OPERAND_WIDTH-1:0];
        bus.SelA        = exe_ctrl.sel_a;
        bus.SelB        = exe_ctrl.sel_b;
        bus.Op          = exe_ctrl.op;
        bus.WrAcc       = bus.enable & exe_ctrl.wr_acc;
        bus.wr_ram      = bus.enable & exe_ctrl.wr_ram;
        if (bus.enable) begin
          count_d = count_q + 1'b1;
          if (exe_ctrl.is_halt) begin
            state_d = HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc_out      = pc_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: per-cycle comparison against an instruction-level
// model, plus literal expectations at hand-computed cycles of each scenario.
module tb_bip_control;
  import bip_pkg::*;

  logic clk = 1'b0;
  logic reset;
  bip_if bus ();

  bip_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] prog [0:2047];
  assign bus.instr_in = prog[bus.pc_out];

  int          checks   = 0;
  int          failures = 0;
  logic        rst_nxt;
  logic        en_nxt;

  // Model: phase 0..3 = fetch, decode, execute, halted
  int          m_phase = 0;
  int          m_pc    = 0;
  int          m_count = 0;
  logic [15:0] m_ir    = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] fetched;
    fetched = prog[m_pc];
    if (!reset) begin
      m_phase = 0; m_pc = 0; m_ir = 16'h0000; m_count = 0;
    end else if (m_phase != 3 && bus.enable) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_ir    = fetched;
        m_phase = 2;
      end else begin
        m_count = (m_count + 1) % 65536;
        if (m_ir[15:11] == 5'd0) begin
          m_phase = 3;
        end else begin
          m_pc    = (m_pc + 1) % 2048;
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    int e_sela, e_selb, e_op, e_wracc, e_wr, e_rd, e_imm, opc;
    logic [15:0] fetched;
    e_sela = 0; e_selb = 0; e_op = 0; e_wracc = 0; e_wr = 0; e_rd = 0; e_imm = 0;
    fetched = prog[m_pc];
    if (m_phase == 1) begin
      opc = int'(fetched[15:11]);
      if (bus.enable && (opc == 2 || opc == 4 || opc == 6)) e_rd = 1;
    end
    if (m_phase == 2) begin
      opc   = int'(m_ir[15:11]);
      e_imm = int'(m_ir[10:0]);
      case (opc)
        1: e_wr = 1;
        2: e_wracc = 1;
        3: begin e_sela = 1; e_wracc = 1; end
        4: begin e_sela = 2; e_wracc = 1; end
        5: begin e_sela = 2; e_selb = 1; e_wracc = 1; end
        6: begin e_sela = 2; e_op = 1; e_wracc = 1; end
        7: begin e_sela = 2; e_selb = 1; e_op = 1; e_wracc = 1; end
        default: ;
      endcase
      if (!bus.enable) begin e_wracc = 0; e_wr = 0; end
      chk("exec_data_addr", 32'(bus.data_addr), 32'(m_ir[10:0]));
    end
    chk("pc_out",      32'(bus.pc_out),      m_pc);
    chk("instr_count", 32'(bus.instr_count), m_count);
    chk("halted",      32'(bus.halted),      (m_phase == 3) ? 1 : 0);
    chk("SelA",        32'(bus.SelA),        e_sela);
    chk("SelB",        32'(bus.SelB),        e_selb);
    chk("Op",          32'(bus.Op),          e_op);
    chk("WrAcc",       32'(bus.WrAcc),       e_wracc);
    chk("wr_ram",      32'(bus.wr_ram),      e_wr);
    chk("rd_ram",      32'(bus.rd_ram),      e_rd);
    chk("imm_operand", 32'(bus.imm_operand), e_imm);
    if (e_rd == 1) chk("rd_data_addr", 32'(bus.data_addr), 32'(fetched[10:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    reset      = rst_nxt;
    bus.enable = en_nxt;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_nxt = 1'b0;
    en_nxt  = 1'b1;
    tick();
    tick();
    rst_nxt = 1'b1;
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 2048; a++) prog[a] = 16'hF800;
  endtask

  initial begin
    int wr_cnt;
    int wracc_seen;
    reset      = 1'b0;
    bus.enable = 1'b1;
    rst_nxt    = 1'b0;
    en_nxt     = 1'b1;
    clear_prog();

    // LDI 5, ADDI 4, HLT
    prog[0] = 16'h1805; prog[1] = 16'h2804; prog[2] = 16'h0000;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      tick();
      if (c == 0) begin
        chk("rst_pc",     32'(bus.pc_out),      0);
        chk("rst_count",  32'(bus.instr_count), 0);
        chk("rst_halted", 32'(bus.halted),      0);
        chk("rst_wracc",  32'(bus.WrAcc),       0);
      end
      if (c == 2) begin
        chk("ldi_sela",  32'(bus.SelA),        1);
        chk("ldi_imm",   32'(bus.imm_operand), 5);
        chk("ldi_wracc", 32'(bus.WrAcc),       1);
      end
      if (c == 5) begin
        chk("addi_sela",  32'(bus.SelA),        2);
        chk("addi_selb",  32'(bus.SelB),        1);
        chk("addi_op",    32'(bus.Op),          0);
        chk("addi_imm",   32'(bus.imm_operand), 4);
        chk("addi_wracc", 32'(bus.WrAcc),       1);
      end
      if (c >= 9) begin
        chk("hlt_halted", 32'(bus.halted),      1);
        chk("hlt_pc",     32'(bus.pc_out),      2);
        chk("hlt_count",  32'(bus.instr_count), 3);
      end
    end

    // LD 0x010, SUB 0x011, HLT
    clear_prog();
    prog[0] = 16'h1010; prog[1] = 16'h3011; prog[2] = 16'h0000;
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        chk("ld_rd",   32'(bus.rd_ram),    1);
        chk("ld_addr", 32'(bus.data_addr), 32'h010);
      end
      if (c == 2) begin
        chk("ld_sela",  32'(bus.SelA),  0);
        chk("ld_wracc", 32'(bus.WrAcc), 1);
      end
      if (c == 4) begin
        chk("sub_rd",   32'(bus.rd_ram),    1);
        chk("sub_addr", 32'(bus.data_addr), 32'h011);
      end
      if (c == 5) begin
        chk("sub_sela",  32'(bus.SelA),  2);
        chk("sub_selb",  32'(bus.SelB),  0);
        chk("sub_op",    32'(bus.Op),    1);
        chk("sub_wracc", 32'(bus.WrAcc), 1);
        chk("sub_rd_ex", 32'(bus.rd_ram), 0);
      end
    end

    // STO 0x7FF, HLT
    clear_prog();
    prog[0] = 16'h0FFF; prog[1] = 16'h0000;
    do_reset();
    wr_cnt = 0;
    wracc_seen = 0;
    for (int c = 0; c <= 8; c++) begin
      tick();
      if (bus.wr_ram === 1'b1 && bus.data_addr === 11'h7FF) wr_cnt++;
      if (bus.WrAcc !== 1'b0) wracc_seen = 1;
    end
    chk("sto_wr_cycles", wr_cnt, 1);
    chk("sto_wracc",     wracc_seen, 0);

    // Enable dropped for 4 cycles over EXECUTE of ADDI
    clear_prog();
    prog[0] = 16'h1801; prog[1] = 16'h2804; prog[2] = 16'h0000;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      en_nxt = (c >= 5 && c <= 8) ? 1'b0 : 1'b1;
      tick();
      if (c >= 5 && c <= 8) begin
        chk("en_wracc", 32'(bus.WrAcc),       0);
        chk("en_pc",    32'(bus.pc_out),      1);
        chk("en_count", 32'(bus.instr_count), 1);
      end
      if (c == 9) begin
        chk("en_back_wracc", 32'(bus.WrAcc),       1);
        chk("en_back_sela",  32'(bus.SelA),        2);
        chk("en_back_imm",   32'(bus.imm_operand), 4);
      end
      if (c == 10) begin
        chk("en_after_pc",    32'(bus.pc_out),      2);
        chk("en_after_count", 32'(bus.instr_count), 2);
        chk("en_after_wracc", 32'(bus.WrAcc),       0);
      end
    end
    en_nxt = 1'b1;

    // PC wrap: 2048 NOPs (opcode 11111)
    clear_prog();
    do_reset();
    for (int c = 0; c <= 6145; c++) begin
      tick();
      if (c == 6143) begin
        chk("wrap_pc_last", 32'(bus.pc_out), 2047);
        chk("wrap_nop_strobes", 32'(bus.WrAcc) + 32'(bus.wr_ram) + 32'(bus.rd_ram), 0);
      end
      if (c == 6144) begin
        chk("wrap_pc_zero", 32'(bus.pc_out),      0);
        chk("wrap_count",   32'(bus.instr_count), 2048);
      end
    end

    // Reset asserted during DECODE of LD
    clear_prog();
    prog[0] = 16'h1807; prog[1] = 16'h1005;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      rst_nxt = (c == 4) ? 1'b0 : 1'b1;
      tick();
      if (c == 4) begin
        chk("mid_rd",    32'(bus.rd_ram),      1);
        chk("mid_count", 32'(bus.instr_count), 1);
      end
      if (c == 5) begin
        chk("mid_rst_pc",     32'(bus.pc_out),      0);
        chk("mid_rst_rd",     32'(bus.rd_ram),      0);
        chk("mid_rst_count",  32'(bus.instr_count), 0);
        chk("mid_rst_halted", 32'(bus.halted),      0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
